// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one host read/write command into a
// complete AW/W/B or AR/R transaction, with an optional per-transaction watchdog.
module axi4_lite_master #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_tmo,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);
    localparam int unsigned     WD_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t          state;
    logic            aw_done;
    logic            w_done;
    logic [WD_W-1:0] wd_cnt;

    logic aw_hs_c;
    logic w_hs_c;
    logic aw_done_c;
    logic w_done_c;
    logic wd_expire_c;

    // Handshake detection and watchdog expiry; these only feed registered state.
    always_comb begin
        aw_hs_c     = AWVALID && AWREADY;
        w_hs_c      = WVALID && WREADY;
        aw_done_c   = aw_done || aw_hs_c;
        w_done_c    = w_done || w_hs_c;
        wd_expire_c = (TIMEOUT != 0) && (state != IDLE) && (wd_cnt == WD_LAST);
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wd_cnt    <= '0;
            cmd_ready <= 1'b1;
            rsp_done  <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            rsp_tmo   <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
        end else begin
            rsp_done <= 1'b0;
            if (state != IDLE) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            // Watchdog wins over any handshake landing on the same edge.
            if (wd_expire_c) begin
                state     <= IDLE;
                AWVALID   <= 1'b0;
                WVALID    <= 1'b0;
                BREADY    <= 1'b0;
                ARVALID   <= 1'b0;
                RREADY    <= 1'b0;
                cmd_ready <= 1'b1;
                rsp_done  <= 1'b1;
                rsp_tmo   <= 1'b1;
                rsp_resp  <= RESP_SLVERR;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            wd_cnt    <= '0;
                            cmd_ready <= 1'b0;
                            if (cmd_write) begin
                                AWADDR  <= cmd_addr;
                                WDATA   <= cmd_wdata;
                                AWVALID <= 1'b1;
                                WVALID  <= 1'b1;
                                aw_done <= 1'b0;
                                w_done  <= 1'b0;
                                state   <= WR_ADDR_DATA;
                            end else begin
                                ARADDR  <= cmd_addr;
                                ARVALID <= 1'b1;
                                state   <= RD_ADDR;
                            end
                        end
                    end
                    WR_ADDR_DATA: begin
                        if (aw_hs_c) begin
                            AWVALID <= 1'b0;
                        end
                        if (w_hs_c) begin
                            WVALID <= 1'b0;
                        end
                        aw_done <= aw_done_c;
                        w_done  <= w_done_c;
                        if (aw_done_c && w_done_c) begin
                            BREADY <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (BVALID) begin
                            BREADY    <= 1'b0;
                            rsp_resp  <= BRESP;
                            rsp_tmo   <= 1'b0;
                            rsp_done  <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    RD_ADDR: begin
                        if (ARREADY) begin
                            ARVALID <= 1'b0;
                            RREADY  <= 1'b1;
                            state   <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (RVALID) begin
                            RREADY    <= 1'b0;
                            rsp_rdata <= RDATA;
                            rsp_resp  <= RRESP;
                            rsp_tmo   <= 1'b0;
                            rsp_done  <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_master.sv
// Randomised bench for axi4_lite_master: reactive slave with per-transaction delays,
// and a timeline model deriving every output from the command and those delays.
module tb_axi4_lite_master;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic          ACLK;
    logic          ARESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_done;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_tmo;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    axi4_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_tmo(rsp_tmo),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          aw_d;
        int          w_d;
        int          b_d;
        int          ar_d;
        int          r_d;
        logic [1:0]  resp;
        int          gap;
    } cmd_t;

    cmd_t        q[$];
    cmd_t        cur;
    logic [31:0] mem [16];

    int n_pass;
    int n_total;

    // Model state: k counts cycles since acceptance, d_eff is the done cycle.
    bit          has_txn;
    int          k;
    int          d_eff;
    bit          tmo_exp;
    logic [31:0] exp_rdata_new;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_resp;

    bit          s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_mem_done;
    int          s_aw_cnt, s_w_cnt, s_b_cnt, s_ar_cnt, s_r_cnt;
    logic [3:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;

    int          st_awv, st_wv, st_rrdy, st_busy, st_ndone, st_done_k, st_bhs;
    bit          st_b2b, st_tmo, st_bready_done;
    logic [31:0] st_rdata, st_wdata;
    logic [3:0]  st_awaddr;
    logic [1:0]  st_resp;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic cmd_t mk_cmd(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                                    input int aw_d, input int w_d, input int b_d,
                                    input int ar_d, input int r_d, input logic [1:0] resp,
                                    input int gap);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata;
        c.aw_d = aw_d; c.w_d = w_d; c.b_d = b_d; c.ar_d = ar_d; c.r_d = r_d;
        c.resp = resp; c.gap = gap;
        return c;
    endfunction

    function automatic int rdly();
        return ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic slave_quiet();
        s_aw_hs = 1; s_w_hs = 1; s_b_hs = 1; s_ar_hs = 1; s_r_hs = 1; s_mem_done = 1;
        s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0; s_ar_cnt = 0; s_r_cnt = 0;
    endtask

    // Compare every DUT output against the timeline implied by the current command.
    task automatic check_cycle();
        bit busy;
        bit done;
        int mx;
        busy = has_txn && (k < d_eff);
        done = has_txn && (k == d_eff);
        mx   = imax(cur.aw_d, cur.w_d);
        if (done) begin
            hold_resp = tmo_exp ? 2'b10 : cur.resp;
            if (!cur.wr && !tmo_exp) hold_rdata = exp_rdata_new;
        end
        chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
        chk("rsp_done", 32'(rsp_done), 32'(done));
        chk("rsp_rdata", rsp_rdata, hold_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(hold_resp));
        if (done) chk("rsp_tmo", 32'(rsp_tmo), 32'(tmo_exp));
        chk("AWVALID", 32'(AWVALID), 32'(busy && cur.wr && (k <= cur.aw_d)));
        chk("WVALID", 32'(WVALID), 32'(busy && cur.wr && (k <= cur.w_d)));
        chk("BREADY", 32'(BREADY), 32'(busy && cur.wr && (k > mx)));
        chk("ARVALID", 32'(ARVALID), 32'(busy && !cur.wr && (k <= cur.ar_d)));
        chk("RREADY", 32'(RREADY), 32'(busy && !cur.wr && (k > cur.ar_d)));
        if (busy && cur.wr && (k <= cur.aw_d)) chk("AWADDR", 32'(AWADDR), 32'(cur.addr));
        if (busy && cur.wr && (k <= cur.w_d)) chk("WDATA", WDATA, cur.wdata);
        if (busy && !cur.wr && (k <= cur.ar_d)) chk("ARADDR", 32'(ARADDR), 32'(cur.addr));
        if (has_txn && (k <= d_eff)) begin
            if (AWVALID) begin st_awv++; st_awaddr = AWADDR; end
            if (WVALID) begin st_wv++; st_wdata = WDATA; end
            if (RREADY) st_rrdy++;
            if (!cmd_ready) st_busy++;
            if (rsp_done) begin
                st_ndone++; st_done_k = k; st_rdata = rsp_rdata; st_resp = rsp_resp;
                st_tmo = rsp_tmo; st_bready_done = BREADY;
            end
        end
    endtask

    // Reactive register-file slave; each channel waits its own delay.
    task automatic drive_slave();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        AWREADY = AWVALID && !s_aw_hs && (s_aw_cnt >= cur.aw_d);
        WREADY  = WVALID && !s_w_hs && (s_w_cnt >= cur.w_d);
        BVALID  = s_aw_hs && s_w_hs && !s_b_hs && (s_b_cnt >= cur.b_d);
        BRESP   = BVALID ? cur.resp : 2'($urandom);
        ARREADY = ARVALID && !s_ar_hs && (s_ar_cnt >= cur.ar_d);
        RVALID  = s_ar_hs && !s_r_hs && (s_r_cnt >= cur.r_d);
        RDATA   = RVALID ? mem[s_araddr] : 32'($urandom);
        RRESP   = RVALID ? cur.resp : 2'($urandom);
        aw_hs = AWVALID && AWREADY;
        w_hs  = WVALID && WREADY;
        b_hs  = BVALID && BREADY;
        ar_hs = ARVALID && ARREADY;
        r_hs  = RVALID && RREADY;
        if (s_aw_hs && s_w_hs && !s_b_hs) s_b_cnt++;
        if (s_ar_hs && !s_r_hs) s_r_cnt++;
        if (aw_hs) begin s_aw_hs = 1; s_awaddr = AWADDR; end else if (AWVALID) s_aw_cnt++;
        if (w_hs) begin s_w_hs = 1; s_wdata = WDATA; end else if (WVALID) s_w_cnt++;
        if (ar_hs) begin s_ar_hs = 1; s_araddr = ARADDR; end else if (ARVALID) s_ar_cnt++;
        if (b_hs) begin s_b_hs = 1; st_bhs++; end
        if (r_hs) s_r_hs = 1;
        if (s_aw_hs && s_w_hs && !s_mem_done) begin
            mem[s_awaddr] = s_wdata;
            s_mem_done = 1;
        end
    endtask

    task automatic drive_cmd();
        bit busy;
        int dn;
        busy = has_txn && (k < d_eff);
        if (q.size() > 0 && q[0].gap > 0) q[0].gap--;
        if (q.size() > 0 && q[0].gap == 0) begin
            cmd_valid = 1'b1;
            cmd_write = q[0].wr;
            cmd_addr  = q[0].addr;
            cmd_wdata = q[0].wdata;
        end else begin
            cmd_valid = busy ? 1'($urandom) : 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 4'($urandom);
            cmd_wdata = 32'($urandom);
        end
        if (cmd_valid && !busy) begin
            st_b2b  = has_txn && (k == d_eff);
            cur     = q.pop_front();
            has_txn = 1;
            dn      = cur.wr ? imax(cur.aw_d, cur.w_d) + 2 + cur.b_d : cur.ar_d + 2 + cur.r_d;
            tmo_exp = (dn >= int'(TMO));
            d_eff   = tmo_exp ? int'(TMO) : dn;
            exp_rdata_new = mem[cur.addr];
            s_aw_hs = !cur.wr; s_w_hs = !cur.wr; s_b_hs = !cur.wr; s_mem_done = !cur.wr;
            s_ar_hs = cur.wr;  s_r_hs = cur.wr;
            s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0; s_ar_cnt = 0; s_r_cnt = 0;
            st_awv = 0; st_wv = 0; st_rrdy = 0; st_busy = 0; st_ndone = 0; st_bhs = 0;
            st_done_k = -1;
            k = -1;
        end
    endtask

    task automatic cycle();
        @(negedge ACLK);
        check_cycle();
        drive_slave();
        drive_cmd();
        k++;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((q.size() > 0 || (has_txn && k <= d_eff)) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            n_total++;
            $display("FAIL run_budget: got %0d cycles required below %0d", n, budget);
        end
        cycle();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        has_txn = 0; k = 0; d_eff = 0; tmo_exp = 0;
        hold_rdata = '0; hold_resp = '0; exp_rdata_new = '0;
        cur = mk_cmd(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 16; i++) mem[i] = 32'($urandom);
        slave_quiet();
        ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;

        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_valids", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 32'd0);
        chk("reset_rsp", 32'({rsp_done, rsp_tmo, rsp_resp}), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_addr_data", 32'(AWADDR) | 32'(ARADDR) | WDATA, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (2) cycle();

        // Zero-wait write.
        q.push_back(mk_cmd(1, 4'h4, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 0));
        run_until_idle(50);
        chk("zw_latency", 32'(st_done_k + 1), 32'd3);
        chk("zw_awaddr", 32'(st_awaddr), 32'h4);
        chk("zw_wdata", st_wdata, 32'hDEADBEEF);
        chk("zw_resp", 32'(st_resp), 32'd0);

        // Skewed write: AW ready 2 cycles late, W ready 4 cycles late.
        q.push_back(mk_cmd(1, 4'h8, 32'h0BADF00D, 2, 4, 0, 0, 0, 2'b01, 1));
        run_until_idle(50);
        chk("skew_awvalid_cycles", 32'(st_awv), 32'd3);
        chk("skew_wvalid_cycles", 32'(st_wv), 32'd5);
        chk("skew_b_handshakes", 32'(st_bhs), 32'd1);
        chk("skew_done_pulses", 32'(st_ndone), 32'd1);
        chk("skew_resp", 32'(st_resp), 32'd1);

        // Read with RVALID three cycles late.
        mem[12] = 32'h12345678;
        q.push_back(mk_cmd(0, 4'hC, 32'h0, 0, 0, 0, 0, 3, 2'b00, 0));
        run_until_idle(50);
        chk("rd_rdata", st_rdata, 32'h12345678);
        chk("rd_rready_cycles", 32'(st_rrdy), 32'd4);
        chk("rd_latency", 32'(st_done_k + 1), 32'd6);

        // Back-to-back write then read with cmd_valid held throughout.
        q.push_back(mk_cmd(1, 4'h0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2'b00, 0));
        q.push_back(mk_cmd(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0));
        run_until_idle(50);
        chk("b2b_accept_in_done", 32'(st_b2b), 32'd1);
        chk("b2b_rdata", st_rdata, 32'hCAFEF00D);

        // Slave never answers B: watchdog ends the write.
        q.push_back(mk_cmd(1, 4'h2, 32'h55AA55AA, 0, 0, 100, 0, 0, 2'b00, 2));
        run_until_idle(50);
        chk("tmo_done_k", 32'(st_done_k), 32'd8);
        chk("tmo_busy_cycles", 32'(st_busy), 32'd8);
        chk("tmo_flag", 32'(st_tmo), 32'd1);
        chk("tmo_resp", 32'(st_resp), 32'd2);
        chk("tmo_bready", 32'(st_bready_done), 32'd0);
        chk("tmo_rdata_kept", st_rdata, 32'hCAFEF00D);

        // Random traffic, including occasional watchdog expiries.
        for (int i = 0; i < 80; i++) begin
            q.push_back(mk_cmd(1'($urandom), 4'($urandom), 32'($urandom), rdly(), rdly(),
                               rdly(), rdly(), rdly(), 2'($urandom),
                               int'($urandom_range(0, 2))));
        end
        run_until_idle(3000);

        // Reset while ARVALID is held.
        q.push_back(mk_cmd(0, 4'h5, 32'h0, 20, 0, 0, 20, 0, 2'b00, 0));
        repeat (3) cycle();
        @(posedge ACLK);
        #2;
        ARESETn = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_no_done", 32'(rsp_done), 32'd0);
        has_txn = 0; hold_rdata = '0; hold_resp = '0;
        q.delete();
        slave_quiet();
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (3) cycle();

        q.push_back(mk_cmd(1, 4'h6, 32'hA5A5_0001, 0, 0, 0, 0, 0, 2'b00, 0));
        run_until_idle(50);
        chk("post_rst_latency", 32'(st_done_k + 1), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
